// File: rtl/vrf_port_sched_pkg.sv
// vrf_sched_pkg: shared types and constants for the vector register file
// port scheduler. The default widths match the regfile instance.
// No ports (package).
package vrf_sched_pkg;

    localparam int VRF_DATA_WIDTH = 128;
    localparam int VRF_ADDR_WIDTH = 5;
    localparam int VRF_NUM_RD     = 2;
    localparam int VRF_WR_STREAK  = 4;

    // Pointer width for an n-way round robin; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int RR_W = clog2_min1(VRF_NUM_RD);

    typedef enum logic {
        WR_PRIO = 1'b0,
        RD_SLOT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/vrf_port_sched_if.sv
// vrf_port_sched_if: requester-side bundle of the regfile port scheduler.
//   rd_req/rd_addr  : NUM_RD read requests, addr i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_gnt          : one-hot read issue
//   rd_valid/rd_data: one-hot read return, one cycle after rd_gnt
//   wr_req/wr_addr/wr_data/wr_gnt : single writeback requester
// master = requesters (issue/operand-fetch/writeback), slave = scheduler.
interface vrf_port_sched_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic [NUM_RD-1:0]            rd_req;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0]            rd_gnt;
    logic [NUM_RD-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         wr_req;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/vrf_port_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req [N]     : request vector
//   i_ptr [PTR_W] : highest-priority index this cycle (must be < N)
//   o_gnt [N]     : one-hot grant, zero when no request
// The winner is the requester at the smallest circular distance from i_ptr.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    always_comb begin
        int best_d;
        int sel;
        int d;
        best_d = N;
        sel    = 0;
        d      = 0;
        o_gnt  = '0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - int'(i_ptr)) % N;
            if (i_req[i] && (d < best_d)) begin
                best_d = d;
                sel    = i;
            end
        end
        for (int i = 0; i < N; i++)
            o_gnt[i] = (best_d < N) && (sel == i);
    end

endmodule

// File: rtl/vrf_port_sched.sv
// vrf_port_sched: shares the single-port vector regfile between NUM_RD
// operand readers and one writeback port, one regfile access per cycle.
//   clk, rst        : clock, asynchronous active-high reset
//   req_if (slave)  : requester handshakes and read return
//   o_vrf_en/o_vrf_rw/o_vrf_addr/o_vrf_data_in : regfile command
//   i_vrf_data_out  : regfile read data, valid the cycle after a read issue
// Writes normally win; after WR_STREAK consecutive writes with a read
// waiting, one cycle is reserved for a read so readers cannot starve.
// Optional macro VRF_SCHED_WR_BYPASS_EN: a reader waiting on the address
// being written is granted alongside the write and gets the write data
// back from a local register one cycle later.
module vrf_port_sched
    import vrf_sched_pkg::*;
#(
    parameter int DATA_WIDTH = VRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = VRF_ADDR_WIDTH,
    parameter int NUM_RD     = VRF_NUM_RD,
    parameter int WR_STREAK  = VRF_WR_STREAK
) (
    input  logic                  clk,
    input  logic                  rst,
    vrf_port_sched_if.slave       req_if,
    output logic                  o_vrf_en,
    output logic                  o_vrf_rw,
    output logic [ADDR_WIDTH-1:0] o_vrf_addr,
    output logic [DATA_WIDTH-1:0] o_vrf_data_in,
    input  logic [DATA_WIDTH-1:0] i_vrf_data_out
);

    localparam int PTR_W  = clog2_min1(NUM_RD);
    localparam int STRK_W = $clog2(WR_STREAK + 1);

    sched_state_e          r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [STRK_W-1:0]     r_streak, w_streak_nxt, w_streak_inc;
    logic [NUM_RD-1:0]     w_rr_gnt, w_rd_gnt, r_rd_valid;
    logic                  w_wr_gnt, w_rd_any;
    logic [ADDR_WIDTH-1:0] w_rd_addr_sel;
    logic [DATA_WIDTH-1:0] w_rd_ret_data;

    assign w_rd_any     = |req_if.rd_req;
    assign w_streak_inc = r_streak + 1'b1;

    rr_arbiter #(.N(NUM_RD), .PTR_W(PTR_W)) u_rd_arb (
        .i_req (req_if.rd_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt)
    );

`ifdef VRF_SCHED_WR_BYPASS_EN
    logic [NUM_RD-1:0]     w_byp_req, w_byp_gnt;
    logic                  r_byp;
    logic [DATA_WIDTH-1:0] r_byp_data;

    always_comb begin
        w_byp_req = '0;
        for (int i = 0; i < NUM_RD; i++)
            w_byp_req[i] = req_if.rd_req[i] &&
                           (req_if.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == req_if.wr_addr);
    end

    // Second arbiter over address-matching readers only, same pointer.
    rr_arbiter #(.N(NUM_RD), .PTR_W(PTR_W)) u_byp_arb (
        .i_req (w_byp_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_byp_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp <= w_wr_gnt && (|w_rd_gnt);
            if (w_wr_gnt && (|w_rd_gnt))
                r_byp_data <= req_if.wr_data;
        end
    end

    assign w_rd_ret_data = r_byp ? r_byp_data : i_vrf_data_out;
`else
    assign w_rd_ret_data = i_vrf_data_out;
`endif

    // Grants and next state. Grants are forced low while rst is high.
    always_comb begin
        w_wr_gnt     = 1'b0;
        w_rd_gnt     = '0;
        w_state_nxt  = WR_PRIO;
        w_streak_nxt = r_streak;

        if (!rst) begin
            if ((r_state == RD_SLOT) && w_rd_any) begin
                w_rd_gnt = w_rr_gnt;
            end else if (req_if.wr_req) begin
                w_wr_gnt = 1'b1;
`ifdef VRF_SCHED_WR_BYPASS_EN
                w_rd_gnt = w_byp_gnt;
`endif
            end else begin
                w_rd_gnt = w_rr_gnt;
            end
        end

        // RD_SLOT lasts exactly one cycle whatever happened in it.
        if (r_state == RD_SLOT) begin
            w_streak_nxt = '0;
        end else if (!w_rd_any || (|w_rd_gnt)) begin
            w_streak_nxt = '0;
        end else if (w_wr_gnt) begin
            w_streak_nxt = w_streak_inc;
            if (w_streak_inc == STRK_W'(WR_STREAK))
                w_state_nxt = RD_SLOT;
        end
    end

    always_comb begin
        w_rr_ptr_nxt  = r_rr_ptr;
        w_rd_addr_sel = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_gnt[i]) begin
                w_rr_ptr_nxt  = PTR_W'((i + 1) % NUM_RD);
                w_rd_addr_sel = req_if.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WR_PRIO;
            r_rr_ptr   <= '0;
            r_streak   <= '0;
            r_rd_valid <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_streak   <= w_streak_nxt;
            r_rd_valid <= w_rd_gnt;
        end
    end

    // On a bypass both grants are high; the regfile sees the write.
    assign o_vrf_en      = w_wr_gnt | (|w_rd_gnt);
    assign o_vrf_rw      = w_wr_gnt;
    assign o_vrf_addr    = w_wr_gnt ? req_if.wr_addr : w_rd_addr_sel;
    assign o_vrf_data_in = w_wr_gnt ? req_if.wr_data : '0;

    assign req_if.rd_gnt   = w_rd_gnt;
    assign req_if.wr_gnt   = w_wr_gnt;
    assign req_if.rd_valid = r_rd_valid;
    assign req_if.rd_data  = (|r_rd_valid) ? w_rd_ret_data : '0;

endmodule
